// File: rtl/ascon_aead128_ctrl.sv
// Control sequencer for Ascon-AEAD128: steps the datapath through init, AD absorb,
// message absorb, finalization and tag, and drives an external permutation core.
module ascon_aead128_ctrl #(
   parameter int unsigned RND_INIT = 12,
   parameter int unsigned RND_DATA = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       decrypt,
   input  logic       ad_empty,
   input  logic       ad_valid,
   input  logic       ad_last,
   output logic       ad_ready,
   input  logic       msg_valid,
   input  logic       msg_last,
   output logic       msg_ready,
   output logic       perm_start,
   output logic [3:0] perm_rounds,
   input  logic       perm_done,
   output logic       st_load,
   output logic       st_key_lo,
   output logic       st_absorb_ad,
   output logic       st_dsep,
   output logic       st_absorb_msg,
   output logic       st_key_fin,
   output logic       tag_valid,
   output logic       busy,
   output logic       decrypt_lat,
   output logic [3:0] state_dbg
);

   // Handshake: a block transfers on a cycle where *_valid and *_ready are both 1;
   // *_ready depends on state only, and valid is ignored in every other state.

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_LOAD    = 4'd1,
      S_P_INIT  = 4'd2,
      S_KEY_LO  = 4'd3,
      S_AD      = 4'd4,
      S_P_AD    = 4'd5,
      S_DSEP    = 4'd6,
      S_MSG     = 4'd7,
      S_P_MSG   = 4'd8,
      S_KEY_FIN = 4'd9,
      S_P_FIN   = 4'd10,
      S_TAG     = 4'd11
   } state_e;

   localparam logic [3:0] RI = 4'(RND_INIT);
   localparam logic [3:0] RD = 4'(RND_DATA);

   state_e     state_q, state_d;
   logic       decrypt_q, decrypt_d;
   logic       ad_empty_q, ad_empty_d;
   logic       ad_last_q, ad_last_d;
   logic [3:0] rounds_q, rounds_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         decrypt_q  <= 1'b0;
         ad_empty_q <= 1'b0;
         ad_last_q  <= 1'b0;
         rounds_q   <= 4'd0;
      end else begin
         decrypt_q  <= decrypt_d;
         ad_empty_q <= ad_empty_d;
         ad_last_q  <= ad_last_d;
         rounds_q   <= rounds_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      decrypt_d  = decrypt_q;
      ad_empty_d = ad_empty_q;
      ad_last_d  = ad_last_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_LOAD;
               decrypt_d  = decrypt;
               ad_empty_d = ad_empty;
            end
         end
         S_LOAD:   state_d = S_P_INIT;
         S_P_INIT: if (perm_done) state_d = S_KEY_LO;
         S_KEY_LO: state_d = ad_empty_q ? S_DSEP : S_AD;
         S_AD: begin
            if (ad_valid) begin
               state_d   = S_P_AD;
               ad_last_d = ad_last;
            end
         end
         S_P_AD:   if (perm_done) state_d = ad_last_q ? S_DSEP : S_AD;
         S_DSEP:   state_d = S_MSG;
         S_MSG: begin
            if (msg_valid) state_d = msg_last ? S_KEY_FIN : S_P_MSG;
         end
         S_P_MSG:   if (perm_done) state_d = S_MSG;
         S_KEY_FIN: state_d = S_P_FIN;
         S_P_FIN:   if (perm_done) state_d = S_TAG;
         S_TAG:     state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // perm_rounds carries the new count on the start cycle, then the held copy.
   always_comb begin
      ad_ready      = 1'b0;
      msg_ready     = 1'b0;
      perm_start    = 1'b0;
      perm_rounds   = rounds_q;
      st_load       = 1'b0;
      st_key_lo     = 1'b0;
      st_absorb_ad  = 1'b0;
      st_dsep       = 1'b0;
      st_absorb_msg = 1'b0;
      st_key_fin    = 1'b0;
      tag_valid     = 1'b0;
      case (state_q)
         S_LOAD: begin
            st_load     = 1'b1;
            perm_start  = 1'b1;
            perm_rounds = RI;
         end
         S_KEY_LO: st_key_lo = 1'b1;
         S_AD: begin
            ad_ready = 1'b1;
            if (ad_valid) begin
               st_absorb_ad = 1'b1;
               perm_start   = 1'b1;
               perm_rounds  = RD;
            end
         end
         S_DSEP: st_dsep = 1'b1;
         S_MSG: begin
            msg_ready = 1'b1;
            if (msg_valid) begin
               st_absorb_msg = 1'b1;
               if (!msg_last) begin
                  perm_start  = 1'b1;
                  perm_rounds = RD;
               end
            end
         end
         S_KEY_FIN: begin
            st_key_fin  = 1'b1;
            perm_start  = 1'b1;
            perm_rounds = RI;
         end
         S_TAG:   tag_valid = 1'b1;
         default: ;
      endcase
   end

   assign rounds_d    = perm_start ? perm_rounds : rounds_q;
   assign busy        = (state_q != S_IDLE);
   assign decrypt_lat = decrypt_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_ascon_aead128_ctrl.sv
// Directed bench for ascon_aead128_ctrl: records every strobe/perm_start with its cycle
// offset from start and compares against hand-derived traces.
module tb_ascon_aead128_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, decrypt = 1'b0, ad_empty = 1'b0;
   logic       ad_valid = 1'b0, ad_last = 1'b0, msg_valid = 1'b0, msg_last = 1'b0;
   logic       perm_done = 1'b0;
   logic       ad_ready, msg_ready, perm_start;
   logic [3:0] perm_rounds;
   logic       st_load, st_key_lo, st_absorb_ad, st_dsep, st_absorb_msg, st_key_fin;
   logic       tag_valid, busy, decrypt_lat;
   logic [3:0] state_dbg;

   ascon_aead128_ctrl #(.RND_INIT(12), .RND_DATA(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .ad_empty(ad_empty),
      .ad_valid(ad_valid), .ad_last(ad_last), .ad_ready(ad_ready),
      .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready),
      .perm_start(perm_start), .perm_rounds(perm_rounds), .perm_done(perm_done),
      .st_load(st_load), .st_key_lo(st_key_lo), .st_absorb_ad(st_absorb_ad),
      .st_dsep(st_dsep), .st_absorb_msg(st_absorb_msg), .st_key_fin(st_key_fin),
      .tag_valid(tag_valid), .busy(busy), .decrypt_lat(decrypt_lat), .state_dbg(state_dbg)
   );

   localparam int E_LOAD = 0, E_KLO = 1, E_AAD = 2, E_DSEP = 3, E_AMSG = 4, E_KFIN = 5, E_TAG = 6;

   // clock / reset block
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0, bad = 0;
   int t0 = 0, pend = 0, perm_delay = 3, viol = 0;
   logic [19:0] exp_q[$];
   logic [19:0] act_q[$];
   logic [6:0] strb;
   assign strb = {tag_valid, st_key_fin, st_absorb_msg, st_dsep, st_absorb_ad, st_key_lo, st_load};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // permutation core model: perm_done pulses perm_delay cycles after perm_start
   initial forever begin
      @(posedge clk); #1;
      perm_done = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) perm_done = 1'b1;
      end
   end

   // monitor
   initial forever begin
      @(negedge clk);
      if (perm_start) pend = perm_delay;
      if (perm_start || strb != 7'd0)
         act_q.push_back({8'(cyc - t0), (perm_start ? perm_rounds : 4'd0), perm_start, strb});
      if ($countones(strb) > 1 || (perm_start && state_dbg inside {4'd2, 4'd5, 4'd8, 4'd10}))
         viol++;
   end

   task automatic add_exp(input int off, input int rnd, input logic ps, input int idx);
      logic [6:0] s;
      s = 7'(1 << idx);
      exp_q.push_back({8'(off), 4'(rnd), ps, s});
   endtask

   task automatic cmp_trace(input string tag);
      int n;
      check({tag, "_len"}, act_q.size(), exp_q.size());
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("%s_ev%0d", tag, i), act_q[i], exp_q[i]);
      act_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_sig(input string tag, input int which);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         case (which)
            0:       hit = ad_ready;
            1:       hit = msg_ready;
            default: hit = tag_valid;
         endcase
      end
      check(tag, 32'(hit), 32'd1);
   endtask

   // driver: called at posedge+1, returns at posedge+1 of the cycle after tag_valid
   task automatic run_op(input logic dec, input logic ade, input int n_ad, input int n_msg,
                         input int gap);
      int gap_bad;
      act_q.delete();
      decrypt = dec; ad_empty = ade; start = 1'b1; t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      if (!ade) begin
         for (int i = 0; i < n_ad; i++) begin
            if (i == 0 && gap > 0) begin
               gap_bad = 0;
               wait_sig("ad_ready_reach", 0);
               for (int g = 0; g < gap; g++) begin
                  if (g > 0) @(negedge clk);
                  if (!ad_ready || perm_start || strb != 7'd0) gap_bad++;
                  @(posedge clk); #1;
               end
               check("ad_gap_idle", gap_bad, 0);
            end
            ad_valid = 1'b1; ad_last = (i == n_ad - 1);
            wait_sig("ad_hs", 0);
            @(posedge clk); #1;
         end
      end
      ad_valid = 1'b0; ad_last = 1'b0;
      for (int i = 0; i < n_msg; i++) begin
         msg_valid = 1'b1; msg_last = (i == n_msg - 1);
         wait_sig("msg_hs", 1);
         @(posedge clk); #1;
      end
      msg_valid = 1'b0; msg_last = 1'b0;
      wait_sig("tag_seen", 2);
      @(posedge clk); #1;
   endtask

   task automatic exp_short();
      add_exp(1, 12, 1, E_LOAD); add_exp(5, 0, 0, E_KLO); add_exp(6, 0, 0, E_DSEP);
      add_exp(7, 0, 0, E_AMSG); add_exp(8, 12, 1, E_KFIN); add_exp(12, 0, 0, E_TAG);
   endtask

   task automatic exp_long();
      add_exp(1, 12, 1, E_LOAD); add_exp(5, 0, 0, E_KLO);
      add_exp(6, 8, 1, E_AAD); add_exp(10, 8, 1, E_AAD); add_exp(14, 0, 0, E_DSEP);
      add_exp(15, 8, 1, E_AMSG); add_exp(19, 8, 1, E_AMSG); add_exp(23, 0, 0, E_AMSG);
      add_exp(24, 12, 1, E_KFIN); add_exp(28, 0, 0, E_TAG);
   endtask

   initial begin
      int hold_bad;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outs", {busy, ad_ready, msg_ready, perm_start, strb, decrypt_lat}, 0);
      check("rst_rounds", perm_rounds, 0);
      check("rst_state", state_dbg, 0);

      // start in the same cycle reset releases: no AD, one final message block
      rst_n = 1'b1;
      exp_short();
      run_op(1'b0, 1'b1, 0, 1, 0);
      cmp_trace("no_ad");

      // two AD blocks, three message blocks, encrypt then decrypt
      exp_long();
      run_op(1'b0, 1'b0, 2, 3, 0);
      cmp_trace("enc_long");
      check("enc_mode", decrypt_lat, 0);
      exp_long();
      run_op(1'b1, 1'b0, 2, 3, 0);
      cmp_trace("dec_long");
      check("dec_mode", decrypt_lat, 1);

      // AD valid withheld for 5 cycles
      add_exp(1, 12, 1, E_LOAD); add_exp(5, 0, 0, E_KLO); add_exp(11, 8, 1, E_AAD);
      add_exp(15, 0, 0, E_DSEP); add_exp(16, 0, 0, E_AMSG); add_exp(17, 12, 1, E_KFIN);
      add_exp(21, 0, 0, E_TAG);
      run_op(1'b0, 1'b0, 1, 1, 5);
      cmp_trace("ad_gap");

      // long P_AD with noise on start/msg_valid/ad_valid
      act_q.delete();
      decrypt = 1'b0; ad_empty = 1'b0; start = 1'b1; t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0; ad_valid = 1'b1; ad_last = 1'b1;
      @(posedge clk); #1;
      perm_delay = 20;
      wait_sig("ad_hs_slow", 0);
      @(posedge clk); #1;
      msg_valid = 1'b1; msg_last = 1'b1; start = 1'b1;
      hold_bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (state_dbg !== 4'd5 || ad_ready || msg_ready || perm_start || strb != 7'd0 || !busy)
            hold_bad++;
      end
      check("p_ad_hold", hold_bad, 0);
      @(posedge clk); #1;
      start = 1'b0; ad_valid = 1'b0; ad_last = 1'b0; perm_delay = 3;
      wait_sig("msg_hs_slow", 1);
      @(posedge clk); #1;
      msg_valid = 1'b0; msg_last = 1'b0;
      wait_sig("tag_slow", 2);
      @(posedge clk); #1;
      add_exp(1, 12, 1, E_LOAD); add_exp(5, 0, 0, E_KLO); add_exp(6, 8, 1, E_AAD);
      add_exp(27, 0, 0, E_DSEP); add_exp(28, 0, 0, E_AMSG); add_exp(29, 12, 1, E_KFIN);
      add_exp(33, 0, 0, E_TAG);
      cmp_trace("slow_p_ad");

      // asynchronous reset in the middle of P_MSG, then a fresh operation
      act_q.delete();
      decrypt = 1'b1; ad_empty = 1'b1; start = 1'b1; t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0; msg_valid = 1'b1; msg_last = 1'b0;
      wait_sig("msg_hs_rst", 1);
      @(posedge clk); #1;
      msg_valid = 1'b0;
      @(negedge clk);
      check("in_p_msg", state_dbg, 8);
      check("p_msg_rounds", perm_rounds, 8);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_outs", {busy, ad_ready, msg_ready, perm_start, strb, decrypt_lat}, 0);
      check("mid_rst_rounds", perm_rounds, 0);
      check("mid_rst_state", state_dbg, 0);
      pend = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_short();
      run_op(1'b0, 1'b1, 0, 1, 0);
      cmp_trace("after_rst");

      check("onehot_viol", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ascon_aead128_ctrl.md
ASCON_AEAD128_CTRL -- requirements
Module: ascon_aead128_ctrl

Interface
REQ-001 SHALL have parameter RND_INIT, 12, round count for initialization and finalization permutations.
REQ-002 SHALL have parameter RND_DATA, 8, round count for AD/message block permutations.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  begin one AEAD operation; sampled only in IDLE.
REQ-006 decrypt  in  1  mode, latched with start; 1 = decryption.
REQ-007 ad_empty  in  1  latched with start; 1 = no associated data.
REQ-008 ad_valid / ad_last  in  1 / 1  AD block offered / final padded AD block.
REQ-009 ad_ready  out  1  AD block accepted this cycle (ad_valid & ad_ready).
REQ-010 msg_valid / msg_last  in  1 / 1  message block offered / final padded block; upstream always delivers a final block, possibly 0 data bytes.
REQ-011 msg_ready  out  1  message block accepted this cycle.
REQ-012 perm_start  out  1  one-cycle pulse starting the permutation core.
REQ-013 perm_rounds  out  4  round count for the current permutation, stable while waiting for perm_done.
REQ-014 perm_done  in  1  one-cycle completion pulse from the permutation core.
REQ-015 st_load  out  1  datapath loads IV||K||N.
REQ-016 st_key_lo  out  1  datapath xors 0^192||K.
REQ-017 st_absorb_ad  out  1  datapath xors AD block into rate.
REQ-018 st_dsep  out  1  datapath xors domain-separation bit.
REQ-019 st_absorb_msg  out  1  datapath xors or replaces rate per mode, emits output block.
REQ-020 st_key_fin  out  1  datapath xors 0^128||K||0^64.
REQ-021 tag_valid  out  1  tag (S3||S4 xor K) valid this cycle.
REQ-022 busy  out  1  high in every state except IDLE.

Function
REQ-023 FSM states: IDLE, LOAD, P_INIT, KEY_LO, AD, P_AD, DSEP, MSG, P_MSG, KEY_FIN, P_FIN, TAG.
REQ-024 IDLE: start=1 -> LOAD next cycle; latch decrypt, ad_empty.
REQ-025 LOAD: st_load=1 and perm_start=1 with perm_rounds=RND_INIT for one cycle -> P_INIT.
REQ-026 Every P_* state: hold perm_rounds, no st_* strobe, perm_start=0; leave only on perm_done=1.
REQ-027 P_INIT exit -> KEY_LO; KEY_LO: st_key_lo one cycle -> AD if ad_empty=0, else DSEP.
REQ-028 AD: ad_ready=1; on ad_valid: st_absorb_ad=1, perm_start=1, perm_rounds=RND_DATA, -> P_AD; P_AD exit -> DSEP if the accepted block had ad_last=1, else AD.
REQ-029 DSEP: st_dsep one cycle -> MSG.
REQ-030 MSG: msg_ready=1; on msg_valid: st_absorb_msg=1; msg_last=0 -> perm_start (RND_DATA) and P_MSG; msg_last=1 -> KEY_FIN without permutation.
REQ-031 P_MSG exit -> MSG.
REQ-032 KEY_FIN: st_key_fin=1, perm_start=1, perm_rounds=RND_INIT -> P_FIN; P_FIN exit -> TAG.
REQ-033 TAG: tag_valid=1 one cycle -> IDLE.
REQ-034 ad_ready/msg_ready combinational from state only, never dependent on *_valid.
REQ-035 At most one st_* strobe high per cycle; perm_start never asserted while in a P_* state.
REQ-036 start outside IDLE ignored; ad/msg inputs outside AD/MSG ignored.
REQ-037 perm_done outside a P_* state ignored.
REQ-038 Mode (decrypt) affects only the latched level; sequencing identical for both modes.

Reset
REQ-039 rst_n=0 forces IDLE immediately, any state, including mid-permutation.
REQ-040 Reset values: all outputs 0, perm_rounds=0, latched decrypt/ad_empty=0.
REQ-041 First start accepted on the first rising edge after rst_n deasserts.

Verification
REQ-042 ad_empty=1, one msg block with msg_last=1: start, each perm_done 3 cycles after perm_start -> strobe order load, key_lo, dsep, absorb_msg, key_fin, tag_valid; exactly 2 perm_start, rounds 12,12.
REQ-043 2 AD blocks (last on 2nd), 3 msg blocks -> perm_start count 1+2+2+1=6, rounds 12,8,8,8,8,12; exactly one st_dsep, after second P_AD.
REQ-044 ad_valid held low 5 cycles in AD -> ad_ready stays 1, no strobe, no perm_start until valid.
REQ-045 perm_done delayed 20 cycles in P_AD with msg_valid=1 and start=1 -> state held, ad_ready/msg_ready 0, no extra perm_start.
REQ-046 rst_n pulsed low in P_MSG -> all outputs 0 within the same cycle; new start -> LOAD sequence from scratch.
REQ-047 decrypt=1 vs 0 with identical stimulus -> identical strobe/perm_start cycle traces.
